// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch front panel/timebase and stopwatch_ctrl.
// The master drives the buttons, switch and tick; the slave (the controller) drives the control outputs.
interface stopwatch_ctrl_if;
  logic       tick;
  logic       ssr_n;
  logic       lap_n;
  logic       view;
  logic       run;
  logic       clr;
  logic       lap_cap;
  logic       view_sel;
  logic [1:0] state;

  modport master (
    output tick, ssr_n, lap_n, view,
    input  run, clr, lap_cap, view_sel, state
  );

  modport slave (
    input  tick, ssr_n, lap_n, view,
    output run, clr, lap_cap, view_sel, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear and lap controller for a stopwatch.
// Optional button debouncing is enabled with `define STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int TICKS_LONG = 100,
  parameter int TICKS_MIN  = 5,
  parameter int DEB_TICKS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    CLEAR = 2'b11
  } state_e;

  localparam logic [7:0] LONG_C = 8'(TICKS_LONG);
  localparam logic [7:0] MIN_C  = 8'(TICKS_MIN);

  if (TICKS_LONG < 2 || TICKS_LONG > 255 || TICKS_MIN >= TICKS_LONG || DEB_TICKS < 1) begin : g_bad_params
    $error("stopwatch_ctrl: invalid TICKS_LONG/TICKS_MIN/DEB_TICKS");
  end

  logic ssr_meta_q, ssr_sync_q;
  logic lap_meta_q, lap_sync_q;
  logic view_meta_q, view_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ssr_meta_q  <= 1'b1;
      ssr_sync_q  <= 1'b1;
      lap_meta_q  <= 1'b1;
      lap_sync_q  <= 1'b1;
      view_meta_q <= 1'b0;
      view_sync_q <= 1'b0;
    end else begin
      ssr_meta_q  <= bus.ssr_n;
      ssr_sync_q  <= ssr_meta_q;
      lap_meta_q  <= bus.lap_n;
      lap_sync_q  <= lap_meta_q;
      view_meta_q <= bus.view;
      view_sync_q <= view_meta_q;
    end
  end

  logic ssr_s, lap_s;
  logic ssr_lvl, lap_lvl;
  assign ssr_s = ~ssr_sync_q;
  assign lap_s = ~lap_sync_q;

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_TICKS + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_TICKS - 1);

  logic           ssr_deb_q, lap_deb_q;
  logic [DCW-1:0] ssr_dcnt_q, lap_dcnt_q;

  // A level is accepted only after DEB_TICKS consecutive ticks away from the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ssr_deb_q  <= 1'b0;
      lap_deb_q  <= 1'b0;
      ssr_dcnt_q <= '0;
      lap_dcnt_q <= '0;
    end else begin
      if (ssr_s == ssr_deb_q) begin
        ssr_dcnt_q <= '0;
      end else if (bus.tick) begin
        if (ssr_dcnt_q == DEB_LAST) begin
          ssr_deb_q  <= ssr_s;
          ssr_dcnt_q <= '0;
        end else begin
          ssr_dcnt_q <= ssr_dcnt_q + 1'b1;
        end
      end
      if (lap_s == lap_deb_q) begin
        lap_dcnt_q <= '0;
      end else if (bus.tick) begin
        if (lap_dcnt_q == DEB_LAST) begin
          lap_deb_q  <= lap_s;
          lap_dcnt_q <= '0;
        end else begin
          lap_dcnt_q <= lap_dcnt_q + 1'b1;
        end
      end
    end
  end

  assign ssr_lvl = ssr_deb_q;
  assign lap_lvl = lap_deb_q;
`else
  assign ssr_lvl = ssr_s;
  assign lap_lvl = lap_s;
`endif

  logic [1:0] settle_q;
  logic       armed_q;
  logic       ssr_prev_q, lap_prev_q;
  logic [7:0] press_cnt_q;

  // The synchronisers reset to "released", so arming waits until they hold real samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
      ssr_prev_q  <= 1'b0;
      lap_prev_q  <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      if (!settle_q[1]) settle_q <= settle_q + 2'b01;
      if (settle_q[1] && !ssr_s && !ssr_lvl) armed_q <= 1'b1;
      ssr_prev_q <= ssr_lvl;
      lap_prev_q <= lap_lvl;
      if (!ssr_lvl) begin
        press_cnt_q <= 8'd0;
      end else if (armed_q && bus.tick && press_cnt_q != LONG_C) begin
        press_cnt_q <= press_cnt_q + 8'd1;
      end
    end
  end

  logic ssr_rel, long_hit, short_ok, lap_edge;
  assign ssr_rel  = ssr_prev_q & ~ssr_lvl;
  assign long_hit = armed_q & ssr_lvl & bus.tick & (press_cnt_q == LONG_C - 8'd1);
  assign short_ok = armed_q & ssr_rel & (press_cnt_q > MIN_C) & (press_cnt_q < LONG_C);
  assign lap_edge = lap_lvl & ~lap_prev_q;

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   clr_q, clr_d;
  logic   lap_cap_q, lap_cap_d;
  logic   view_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      lap_cap_q  <= 1'b0;
      view_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      lap_cap_q  <= lap_cap_d;
      view_sel_q <= view_sync_q;
    end
  end

  // A long press overrides everything, including a lap capture in the same cycle.
  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    lap_cap_d = 1'b0;
    if (long_hit) begin
      state_d = CLEAR;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (short_ok) state_d = RUN;
        RUN: begin
          if (short_ok) state_d = PAUSE;
          lap_cap_d = lap_edge;
        end
        PAUSE:   if (short_ok) state_d = RUN;
        CLEAR:   if (ssr_rel) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
  end

  assign bus.state    = state_q;
  assign bus.run      = run_q;
  assign bus.clr      = clr_q;
  assign bus.lap_cap  = lap_cap_q;
  assign bus.view_sel = view_sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: start/stop, short-press filtering, long-press clear,
// lap capture, reset during a press, and view latency.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .TICKS_LONG(100),
    .TICKS_MIN (5),
    .DEB_TICKS (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DEBX = 2;
`else
  localparam int DEBX = 0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int clr_seen = 0;
  int lap_seen = 0;
  int clr_base, lap_base;

  always @(posedge clk) begin
    if (bus.clr)     clr_seen <= clr_seen + 1;
    if (bus.lap_cap) lap_seen <= lap_seen + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    cyc(2);
  endtask

  task automatic ssr_down(input int n);
    bus.ssr_n = 1'b0;
    cyc(3);
    repeat (n) tick_pulse();
  endtask

  task automatic ssr_up();
    bus.ssr_n = 1'b1;
    cyc(3);
    repeat (DEBX + 1) tick_pulse();
    cyc(3);
  endtask

  task automatic press(input int n);
    ssr_down(n);
    ssr_up();
  endtask

  task automatic lap_press(input int n);
    bus.lap_n = 1'b0;
    cyc(3);
    repeat (n) tick_pulse();
    bus.lap_n = 1'b1;
    cyc(3);
    repeat (DEBX + 1) tick_pulse();
    cyc(3);
  endtask

  initial begin
    bus.tick  = 1'b0;
    bus.ssr_n = 1'b1;
    bus.lap_n = 1'b1;
    bus.view  = 1'b1;
    rst       = 1'b1;
    cyc(3);
    chk("rst_state",    int'(bus.state),    0);
    chk("rst_run",      int'(bus.run),      0);
    chk("rst_clr",      int'(bus.clr),      0);
    chk("rst_lap_cap",  int'(bus.lap_cap),  0);
    chk("rst_view_sel", int'(bus.view_sel), 0);
    rst = 1'b0;
    cyc(2);
    chk("view_lat2", int'(bus.view_sel), 0);
    cyc(1);
    chk("view_lat3", int'(bus.view_sel), 1);
    bus.view = 1'b0;
    cyc(5);

    // count == TICKS_MIN is too short to start
    press(5);
    chk("min_boundary_state", int'(bus.state), 0);

    ssr_down(20);
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    ssr_up();
`else
    bus.ssr_n = 1'b1;
    cyc(1);
    chk("start_state_pre", int'(bus.state), 0);
    cyc(1);
    chk("start_run_pre", int'(bus.run), 0);
    cyc(1);
    cyc(0);
`endif
    chk("start_state", int'(bus.state), 1);
    chk("start_run",   int'(bus.run),   1);
    cyc(6);

    press(3);
    chk("short3_state", int'(bus.state), 1);

    lap_base = lap_seen;
    lap_press(10);
    chk("lap_run_pulses", lap_seen - lap_base, 1);
    chk("lap_run_state",  int'(bus.state), 1);

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    lap_base = lap_seen;
    bus.lap_n = 1'b0;
    cyc(3);
    tick_pulse();
    bus.lap_n = 1'b1;
    cyc(3);
    repeat (3) tick_pulse();
    cyc(3);
    chk("lap_glitch_pulses", lap_seen - lap_base, 0);
`endif

    press(20);
    chk("pause_state", int'(bus.state), 2);
    chk("pause_run",   int'(bus.run),   0);

    lap_base = lap_seen;
    lap_press(10);
    chk("lap_pause_pulses", lap_seen - lap_base, 0);

    clr_base = clr_seen;
    ssr_down(100 + DEBX);
    chk("long_state",  int'(bus.state), 3);
    chk("long_run",    int'(bus.run),   0);
    chk("long_clr_n",  clr_seen - clr_base, 1);
    ssr_up();
    chk("clear_exit_state", int'(bus.state), 0);
    chk("clear_exit_clr_n", clr_seen - clr_base, 1);

    press(20);
    chk("restart_state", int'(bus.state), 1);
    clr_base = clr_seen;
    ssr_down(50);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_run",   int'(bus.run),   0);
    repeat (60) tick_pulse();
    ssr_up();
    chk("held_rel_state", int'(bus.state), 0);
    chk("held_rel_run",   int'(bus.run),   0);
    chk("held_rel_clr_n", clr_seen - clr_base, 0);

    press(20);
    chk("rearm_state", int'(bus.state), 1);
    chk("rearm_run",   int'(bus.run),   1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
